// File: rtl/univ_shift_pkg.sv
// rtl/univ_shift_pkg.sv - mode encodings and burst FSM states for univ_shift_reg
package univ_shift_pkg;

    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_SHL  = 3'd1;
    localparam logic [2:0] MODE_SHR  = 3'd2;
    localparam logic [2:0] MODE_ROL  = 3'd3;
    localparam logic [2:0] MODE_ROR  = 3'd4;
    localparam logic [2:0] MODE_ASR  = 3'd5;
    localparam logic [2:0] MODE_LOAD = 3'd6;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

endpackage

// File: rtl/univ_shift_reg_shift_core.sv
// rtl/univ_shift_reg_shift_core.sv - combinational next register value and serial-out bit
module shift_core
    import univ_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] po,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic             si,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] po_next,
    output logic             so_upd,
    output logic             so_val
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    int   k_i;
    int   r_i;
    logic sign;

    always_comb begin
        po_next = po;
        so_upd  = 1'b0;
        so_val  = 1'b0;
        k_i     = int'(amt);
        r_i     = k_i % WIDTH;
        sign    = po[WIDTH-1];
        case (mode)
            MODE_SHL: if (k_i != 0) begin
                po_next = (po << k_i) | (~(ONES << k_i) & {WIDTH{si}});
                so_upd  = 1'b1;
                if (k_i >= WIDTH) so_val = si;
                else              so_val = po[IDX_W'(WIDTH - k_i)];
            end
            MODE_SHR: if (k_i != 0) begin
                po_next = (po >> k_i) | (~(ONES >> k_i) & {WIDTH{si}});
                so_upd  = 1'b1;
                if (k_i >= WIDTH) so_val = si;
                else              so_val = po[IDX_W'(k_i - 1)];
            end
            MODE_ASR: if (k_i != 0) begin
                po_next = (po >> k_i) | (~(ONES >> k_i) & {WIDTH{sign}});
                so_upd  = 1'b1;
                if (k_i >= WIDTH) so_val = sign;
                else              so_val = po[IDX_W'(k_i - 1)];
            end
            // A rotate by a whole multiple of WIDTH moves nothing, so so is left alone.
            MODE_ROL: if (r_i != 0) begin
                po_next = (po << r_i) | (po >> (WIDTH - r_i));
                so_upd  = 1'b1;
                so_val  = po[IDX_W'(WIDTH - r_i)];
            end
            MODE_ROR: if (r_i != 0) begin
                po_next = (po >> r_i) | (po << (WIDTH - r_i));
                so_upd  = 1'b1;
                so_val  = po[IDX_W'(r_i - 1)];
            end
            MODE_LOAD: po_next = load_value;
            default: ;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with burst engine; UNIV_SHIFT_PARITY_EN adds registered parity
module univ_shift_reg
    import univ_shift_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               AMT_W       = $clog2(WIDTH),
    parameter int               CNT_W       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic             si,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] po,
    output logic             so,
    output logic             busy,
    output logic             done,
    output logic             parity
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_mode_q, op_mode_d;
    logic [AMT_W-1:0] op_amt_q, op_amt_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic             so_q, so_d;
    logic             done_q, done_d;

    logic [2:0]       core_mode;
    logic [AMT_W-1:0] core_amt;
    logic [WIDTH-1:0] core_po;
    logic             core_so_upd;
    logic             core_so_val;

    // During a burst the latched op drives the core; si/load_value stay live.
    assign core_mode = (state_q == ST_RUN) ? op_mode_q : mode;
    assign core_amt  = (state_q == ST_RUN) ? op_amt_q  : amt;

    shift_core #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_core (
        .po         (po_q),
        .mode       (core_mode),
        .amt        (core_amt),
        .si         (si),
        .load_value (load_value),
        .po_next    (core_po),
        .so_upd     (core_so_upd),
        .so_val     (core_so_val)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_mode_d = op_mode_q;
        op_amt_d  = op_amt_q;
        po_d      = po_q;
        so_d      = so_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_mode_d = mode;
                    op_amt_d  = amt;
                    cnt_d     = burst_len;
                    if (burst_len == '0) done_d  = 1'b1;
                    else                 state_d = ST_RUN;
                end else if (en) begin
                    po_d = core_po;
                    if (core_so_upd) so_d = core_so_val;
                end
            end
            ST_RUN: begin
                po_d = core_po;
                if (core_so_upd) so_d = core_so_val;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_mode_q <= MODE_HOLD;
            op_amt_q  <= '0;
            po_q      <= RESET_VALUE;
            so_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_mode_q <= op_mode_d;
            op_amt_q  <= op_amt_d;
            po_q      <= po_d;
            so_q      <= so_d;
            done_q    <= done_d;
        end
    end

    assign po   = po_q;
    assign so   = so_q;
    assign busy = (state_q == ST_RUN);
    assign done = done_q;

`ifdef UNIV_SHIFT_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = ^po_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) parity_q <= ^RESET_VALUE;
        else      parity_q <= parity_d;
    end

    assign parity = parity_q;
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg (WIDTH=8)
module tb_univ_shift_reg;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [2:0] amt = 3'd0;
    logic       si = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic       start = 1'b0;
    logic [7:0] burst_len = 8'h00;
    logic [7:0] po;
    logic       so;
    logic       busy;
    logic       done;
    logic       parity;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .amt        (amt),
        .si         (si),
        .load_value (load_value),
        .start      (start),
        .burst_len  (burst_len),
        .po         (po),
        .so         (so),
        .busy       (busy),
        .done       (done),
        .parity     (parity)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] m_po = 8'h00;
    logic       m_so = 1'b0;

    typedef struct {
        logic [2:0] md;
        logic [2:0] k;
        logic       s;
        logic [7:0] lv;
        logic [7:0] e_po;
        logic       e_so;
    } vec_t;

    vec_t vt[16];

    function automatic logic exp_par(input logic [7:0] v);
`ifdef UNIV_SHIFT_PARITY_EN
        return ^v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-bit-at-a-time reference: k single shifts, remembering the last bit out.
    task automatic ref_step(input logic [2:0] md, input int k, input logic s, input logic [7:0] lv);
        case (md)
            3'd1: for (int i = 0; i < k; i++) begin m_so = m_po[W-1]; m_po = {m_po[W-2:0], s}; end
            3'd2: for (int i = 0; i < k; i++) begin m_so = m_po[0]; m_po = {s, m_po[W-1:1]}; end
            3'd3: for (int i = 0; i < k % W; i++) begin m_so = m_po[W-1]; m_po = {m_po[W-2:0], m_po[W-1]}; end
            3'd4: for (int i = 0; i < k % W; i++) begin m_so = m_po[0]; m_po = {m_po[0], m_po[W-1:1]}; end
            3'd5: for (int i = 0; i < k; i++) begin m_so = m_po[0]; m_po = {m_po[W-1], m_po[W-1:1]}; end
            3'd6: m_po = lv;
            default: ;
        endcase
    endtask

    task automatic check_model(input string tag, input logic e_busy, input logic e_done);
        check({tag, ".po"}, 32'(po), 32'(m_po));
        check({tag, ".so"}, 32'(so), 32'(m_so));
        check({tag, ".parity"}, 32'(parity), 32'(exp_par(m_po)));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".done"}, 32'(done), 32'(e_done));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_busy;
        int len;
        logic [2:0] bmd;
        logic [2:0] bk;

        vt[0]  = '{3'd6, 3'd0, 1'b0, 8'h81, 8'h81, 1'b0};
        vt[1]  = '{3'd1, 3'd1, 1'b1, 8'h00, 8'h03, 1'b1};
        vt[2]  = '{3'd6, 3'd0, 1'b0, 8'h90, 8'h90, 1'b1};
        vt[3]  = '{3'd5, 3'd3, 1'b1, 8'h00, 8'hF2, 1'b0};
        vt[4]  = '{3'd6, 3'd2, 1'b1, 8'h96, 8'h96, 1'b0};
        vt[5]  = '{3'd3, 3'd3, 1'b1, 8'h00, 8'hB4, 1'b0};
        vt[6]  = '{3'd4, 3'd7, 1'b1, 8'h00, 8'h69, 1'b0};
        vt[7]  = '{3'd1, 3'd0, 1'b1, 8'h00, 8'h69, 1'b0};
        vt[8]  = '{3'd4, 3'd0, 1'b1, 8'h00, 8'h69, 1'b0};
        vt[9]  = '{3'd6, 3'd0, 1'b0, 8'h07, 8'h07, 1'b0};
        vt[10] = '{3'd1, 3'd1, 1'b0, 8'h00, 8'h0E, 1'b0};
        vt[11] = '{3'd6, 3'd0, 1'b0, 8'h03, 8'h03, 1'b0};
        vt[12] = '{3'd0, 3'd5, 1'b1, 8'hFF, 8'h03, 1'b0};
        vt[13] = '{3'd7, 3'd3, 1'b1, 8'hFF, 8'h03, 1'b0};
        vt[14] = '{3'd2, 3'd2, 1'b1, 8'h00, 8'hC0, 1'b1};
        vt[15] = '{3'd2, 3'd1, 1'b0, 8'h00, 8'h60, 1'b0};

        // Reset state
        #2 rst = 1'b0;
        #1;
        check_model("reset", 1'b0, 1'b0);
        step();
        rst = 1'b1;

        // Reset in the third RUN cycle aborts the burst with no done
        mode = 3'd6; load_value = 8'hA5; burst_len = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        check("rstmid.busy0", 32'(busy), 32'd1);
        step();
        check("rstmid.po1", 32'(po), 32'hA5);
        step();
        rst = 1'b0;
        #1;
        check("rstmid.po", 32'(po), 32'h00);
        check("rstmid.busy", 32'(busy), 32'd0);
        check("rstmid.done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstmid.nodone", 32'(done), 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstmid.idle", 32'({busy, done}), 32'd0);
        end
        m_po = 8'h00; m_so = 1'b0;

        // Single-step vector table
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mode = vt[i].md; amt = vt[i].k; si = vt[i].s; load_value = vt[i].lv;
            step();
            check($sformatf("vec%0d.po", i), 32'(po), 32'(vt[i].e_po));
            check($sformatf("vec%0d.so", i), 32'(so), 32'(vt[i].e_so));
            check($sformatf("vec%0d.parity", i), 32'(parity), 32'(exp_par(vt[i].e_po)));
            ref_step(vt[i].md, int'(vt[i].k), vt[i].s, vt[i].lv);
        end

        // Burst SHL x7 from 0x01, with start/en noise while busy
        mode = 3'd6; load_value = 8'h01;
        step();
        ref_step(3'd6, 0, 1'b0, 8'h01);
        check_model("burst.load", 1'b0, 1'b0);
        en = 1'b0; start = 1'b1; mode = 3'd1; amt = 3'd1; si = 1'b0; burst_len = 8'd7;
        step();
        check_model("burst.start", 1'b1, 1'b0);
        n_busy = busy ? 1 : 0;
        en = 1'b1; mode = 3'd6; load_value = 8'hFF; amt = 3'd5; burst_len = 8'd3;
        for (int i = 1; i <= 7; i++) begin
            step();
            ref_step(3'd1, 1, 1'b0, 8'h00);
            check_model($sformatf("burst.op%0d", i), 1'(i < 7), 1'(i == 7));
            if (busy) n_busy++;
        end
        check("burst.final_po", 32'(po), 32'h80);
        check("burst.busy_cycles", 32'(n_busy), 32'd7);
        // Start in the done cycle with burst_len=0; en must lose to start
        start = 1'b1; burst_len = 8'd0; en = 1'b1; mode = 3'd6; load_value = 8'hFF;
        step();
        check_model("len0.done", 1'b0, 1'b1);
        start = 1'b0; en = 1'b0;
        step();
        check_model("len0.after", 1'b0, 1'b0);

        // Random single steps
        for (int i = 0; i < 150; i++) begin
            en = 1'($urandom_range(0, 1));
            mode = 3'($urandom_range(0, 7));
            amt = 3'($urandom_range(0, 7));
            si = 1'($urandom_range(0, 1));
            load_value = 8'($urandom);
            step();
            if (en) ref_step(mode, int'(amt), si, load_value);
            check_model("rand.step", 1'b0, 1'b0);
        end

        // Random back-to-back bursts with live si/load_value
        en = 1'b0;
        for (int b = 0; b < 20; b++) begin
            bmd = 3'($urandom_range(0, 7));
            bk = 3'($urandom_range(0, 7));
            len = int'($urandom_range(0, 5));
            mode = bmd; amt = bk; burst_len = 8'(len); start = 1'b1;
            step();
            check_model("rburst.start", 1'(len != 0), 1'(len == 0));
            for (int j = 0; j < len; j++) begin
                start = 1'($urandom_range(0, 1));
                en = 1'($urandom_range(0, 1));
                mode = 3'($urandom_range(0, 7));
                amt = 3'($urandom_range(0, 7));
                si = 1'($urandom_range(0, 1));
                load_value = 8'($urandom);
                step();
                ref_step(bmd, int'(bk), si, load_value);
                check_model("rburst.op", 1'(j < len - 1), 1'(j == len - 1));
            end
            en = 1'b0;
        end
        start = 1'b0;
        step();
        check("end.done", 32'(done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
